// File: rtl/bcd_to_bin_converter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_to_bin_converter
//  Description : Sequential 4-digit BCD to binary converter.
//                Reverse Double Dabble: each clock shifts {bcd,bin} right by
//                one bit, then subtracts 3 from every BCD digit that is >= 8.
//                Sixteen iterations per conversion, start/busy/done handshake.
//
//  Ports       : clk        - clock, all logic on the rising edge
//                reset      - synchronous, active-high reset
//                start      - conversion request, sampled only when idle
//                BCD_0..3   - units, tens, hundreds, thousands digits
//                busy       - conversion in progress
//                done       - one-cycle pulse when a result or error posts
//                err        - one-cycle pulse with done, an input digit > 9
//                bin_value  - result, zero-extended to 2N bits, held
//
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_bin_converter #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       BCD_0,
    input  logic [3:0]       BCD_1,
    input  logic [3:0]       BCD_2,
    input  logic [3:0]       BCD_3,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2*N-1:0]   bin_value
);

    localparam int c_OUT_W = 2 * N;

    // 9999 needs 14 bits, so the output must be at least that wide.
    generate
        if (N < 7) begin : g_bad_width
            $error("bcd_to_bin_converter: N must be >= 7");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [15:0]          r_bcd;
    logic [15:0]          w_bcd_nxt;
    logic [15:0]          r_bin;
    logic [15:0]          w_bin_nxt;
    logic [3:0]           r_count;
    logic [3:0]           w_count_nxt;
    logic                 r_done;
    logic                 w_done_nxt;
    logic                 r_err;
    logic                 w_err_nxt;
    logic [c_OUT_W-1:0]   r_bin_value;
    logic [c_OUT_W-1:0]   w_bin_value_nxt;

    // One iteration: 32-bit right shift, then per-digit correction.
    logic [31:0]          w_shifted;
    logic [15:0]          w_bcd_shifted;
    logic [15:0]          w_bin_shifted;
    logic [15:0]          w_bcd_adj;
    logic                 w_digit_bad;

    assign w_shifted     = {1'b0, r_bcd, r_bin[15:1]};
    assign w_bcd_shifted = w_shifted[31:16];
    assign w_bin_shifted = w_shifted[15:0];

    // A digit that was odd-weighted before the shift lands at >= 8 and carries
    // an extra +5 of the lower decade; subtracting 3 (i.e. 8 - 5) removes it.
    // The result is always 5..9, so no underflow is possible.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit_adj
            assign w_bcd_adj[4*gi +: 4] = (w_bcd_shifted[4*gi +: 4] >= 4'd8)
                                        ? (w_bcd_shifted[4*gi +: 4] - 4'd3)
                                        : w_bcd_shifted[4*gi +: 4];
        end
    endgenerate

    assign w_digit_bad = (BCD_0 > 4'd9) || (BCD_1 > 4'd9) ||
                         (BCD_2 > 4'd9) || (BCD_3 > 4'd9);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_bcd       <= '0;
            r_bin       <= '0;
            r_count     <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_bin_value <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_bcd       <= w_bcd_nxt;
            r_bin       <= w_bin_nxt;
            r_count     <= w_count_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_bin_value <= w_bin_value_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_bcd_nxt       = r_bcd;
        w_bin_nxt       = r_bin;
        w_count_nxt     = r_count;
        w_done_nxt      = 1'b0;
        w_err_nxt       = 1'b0;
        w_bin_value_nxt = r_bin_value;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_digit_bad) begin
                        // Reject immediately; previous result stays visible.
                        w_done_nxt = 1'b1;
                        w_err_nxt  = 1'b1;
                    end else begin
                        w_bcd_nxt   = {BCD_3, BCD_2, BCD_1, BCD_0};
                        w_bin_nxt   = '0;
                        w_count_nxt = '0;
                        w_state_nxt = ST_CONV;
                    end
                end
            end

            ST_CONV: begin
                w_bcd_nxt   = w_bcd_adj;
                w_bin_nxt   = w_bin_shifted;
                w_count_nxt = r_count + 4'd1;
                if (r_count == 4'd15) begin
                    w_bin_value_nxt = c_OUT_W'(w_bin_shifted);
                    w_done_nxt      = 1'b1;
                    w_state_nxt     = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy      = (r_state == ST_CONV);
    assign done      = r_done;
    assign err       = r_err;
    assign bin_value = r_bin_value;

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_bin_converter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_to_bin_converter
//  Description : Directed self-checking bench for bcd_to_bin_converter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_to_bin_converter;

    localparam int N = 8;

    logic             clk;
    logic             reset;
    logic             start;
    logic [3:0]       BCD_0;
    logic [3:0]       BCD_1;
    logic [3:0]       BCD_2;
    logic [3:0]       BCD_3;
    logic             busy;
    logic             done;
    logic             err;
    logic [2*N-1:0]   bin_value;

    int total;
    int bad;

    bcd_to_bin_converter #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .BCD_0     (BCD_0),
        .BCD_1     (BCD_1),
        .BCD_2     (BCD_2),
        .BCD_3     (BCD_3),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .bin_value (bin_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive digits and hold start for one edge; returns 1 ns after that edge.
    task automatic pulse_start(input logic [3:0] d3, input logic [3:0] d2,
                               input logic [3:0] d1, input logic [3:0] d0);
        BCD_3 = d3; BCD_2 = d2; BCD_1 = d1; BCD_0 = d0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts edges until done (0 if it never arrives) and busy samples seen.
    task automatic wait_done(output int cycles, output int busy_cycles);
        cycles      = 0;
        busy_cycles = busy ? 1 : 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin
                cycles = k;
                break;
            end
            if (busy) busy_cycles++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0;
        BCD_0 = 4'd0; BCD_1 = 4'd0; BCD_2 = 4'd0; BCD_3 = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({busy, done, err} !== 3'b000 || bin_value !== 16'h0000) begin
            bad++;
            $display("FAIL reset_state: busy=%b done=%b err=%b bin=%h required 0/0/0/0000",
                     busy, done, err, bin_value);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        int cyc, bcyc;
        pulse_start(4'd1, 4'd2, 4'd3, 4'd4);
        wait_done(cyc, bcyc);
        total++;
        if (cyc !== 16) begin
            bad++; $display("FAIL basic_latency: got %0d required 16", cyc);
        end
        total++;
        if (bcyc !== 16) begin
            bad++; $display("FAIL basic_busy_cycles: got %0d required 16", bcyc);
        end
        total++;
        if (bin_value !== 16'h04D2 || err !== 1'b0) begin
            bad++; $display("FAIL basic_value: bin=%h err=%b required 04D2 err=0", bin_value, err);
        end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL basic_done_pulse: done=%b busy=%b required 0/0", done, busy);
        end
    endtask

    task automatic test_max;
        int cyc, bcyc;
        pulse_start(4'd9, 4'd9, 4'd9, 4'd9);
        wait_done(cyc, bcyc);
        total++;
        if (cyc !== 16 || bin_value !== 16'h270F || err !== 1'b0) begin
            bad++; $display("FAIL max_9999: cyc=%0d bin=%h err=%b required 16 270F 0",
                            cyc, bin_value, err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_error;
        int busy_seen;
        busy_seen = 0;
        pulse_start(4'd0, 4'd0, 4'hA, 4'd0);
        if (busy) busy_seen++;
        total++;
        if (done !== 1'b1 || err !== 1'b1) begin
            bad++; $display("FAIL err_pulse: done=%b err=%b required 1/1", done, err);
        end
        total++;
        if (bin_value !== 16'h270F) begin
            bad++; $display("FAIL err_hold_value: bin=%h required 270F", bin_value);
        end
        @(posedge clk); #1;
        if (busy) busy_seen++;
        total++;
        if (done !== 1'b0 || err !== 1'b0) begin
            bad++; $display("FAIL err_single_cycle: done=%b err=%b required 0/0", done, err);
        end
        total++;
        if (busy_seen !== 0) begin
            bad++; $display("FAIL err_no_busy: busy samples=%0d required 0", busy_seen);
        end
        // Thousands digit out of range too.
        pulse_start(4'hF, 4'd1, 4'd2, 4'd3);
        total++;
        if (done !== 1'b1 || err !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL err_thousands: done=%b err=%b busy=%b required 1/1/0",
                            done, err, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zero;
        int cyc, bcyc;
        pulse_start(4'd0, 4'd0, 4'd0, 4'd0);
        wait_done(cyc, bcyc);
        total++;
        if (cyc !== 16 || bin_value !== 16'h0000 || err !== 1'b0) begin
            bad++; $display("FAIL zero: cyc=%0d bin=%h err=%b required 16 0000 0",
                            cyc, bin_value, err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int cyc, bcyc;
        pulse_start(4'd1, 4'd2, 4'd3, 4'd4);
        repeat (4) @(posedge clk);
        #1;
        // Start while busy with other digits: must be ignored.
        pulse_start(4'd5, 4'd6, 4'd7, 4'd8);
        wait_done(cyc, bcyc);
        total++;
        if (cyc !== 11 || bin_value !== 16'h04D2) begin
            bad++; $display("FAIL ignored_start: cyc=%0d bin=%h required 11 04D2", cyc, bin_value);
        end
        // New start in the done cycle is accepted.
        pulse_start(4'd5, 4'd6, 4'd7, 4'd8);
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL done_cycle_start: busy=%b required 1", busy);
        end
        wait_done(cyc, bcyc);
        total++;
        if (cyc !== 16 || bin_value !== 16'h162E) begin
            bad++; $display("FAIL back_to_back: cyc=%0d bin=%h required 16 162E", cyc, bin_value);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset;
        int cyc, bcyc, done_seen;
        pulse_start(4'd9, 4'd9, 4'd9, 4'd9);
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        total++;
        if (busy !== 1'b0 || bin_value !== 16'h0000 || done !== 1'b0) begin
            bad++; $display("FAIL mid_reset: busy=%b bin=%h done=%b required 0 0000 0",
                            busy, bin_value, done);
        end
        done_seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done || busy) done_seen++;
        end
        total++;
        if (done_seen !== 0) begin
            bad++; $display("FAIL mid_reset_abort: done/busy samples=%0d required 0", done_seen);
        end
        pulse_start(4'd0, 4'd0, 4'd4, 4'd2);
        wait_done(cyc, bcyc);
        total++;
        if (cyc !== 16 || bin_value !== 16'h002A) begin
            bad++; $display("FAIL after_reset: cyc=%0d bin=%h required 16 002A", cyc, bin_value);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_round_trip;
        int cyc, bcyc, p;
        p = 99 * 101;
        pulse_start(4'((p / 1000) % 10), 4'((p / 100) % 10), 4'((p / 10) % 10), 4'(p % 10));
        wait_done(cyc, bcyc);
        total++;
        if (cyc !== 16 || int'(bin_value) !== p) begin
            bad++; $display("FAIL round_trip: cyc=%0d bin=%0d required 16 %0d", cyc, bin_value, p);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sweep;
        int cyc, bcyc, v;
        v = 0;
        while (v <= 9999) begin
            pulse_start(4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10));
            wait_done(cyc, bcyc);
            total++;
            if (cyc !== 16 || int'(bin_value) !== v || err !== 1'b0) begin
                bad++; $display("FAIL sweep_%0d: cyc=%0d bin=%0d err=%b required 16 %0d 0",
                                v, cyc, bin_value, err, v);
            end
            if (v == 9999) v = 10000;
            else if (v + 37 > 9999) v = 9999;
            else v = v + 37;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        start = 1'b0;
        BCD_0 = '0; BCD_1 = '0; BCD_2 = '0; BCD_3 = '0;
        test_reset();
        test_basic();
        test_max();
        test_error();
        test_zero();
        test_back_to_back();
        test_mid_reset();
        test_round_trip();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
